toy_processor: RTL and testbench

- Single-cycle, 32-bit toy MIPS core executing a three-instruction subset (add, lw, sw) plus a halt marker.
- Self-contained: instruction memory, data memory and register file are internal arrays. The bench preloads them hierarchically and inspects them at end of run.
- Top-level ports are clock and reset only.

---
 rtl/toy_processor.sv | 110 +++++++++++
 tb/tb_toy_processor.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/toy_processor.sv
// Single-cycle 32-bit toy MIPS core: add, lw, sw and a halt word, with internal
// instruction memory, data memory and register file preloaded by the bench.
module toy_processor #(
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 64
) (
    input logic clk,
    input logic reset
);

    localparam int IMEM_AW = $clog2(IMEM_DEPTH);

    localparam logic [5:0]  OP_RTYPE  = 6'h00;
    localparam logic [5:0]  OP_LW     = 6'h23;
    localparam logic [5:0]  OP_SW     = 6'h2B;
    localparam logic [5:0]  FUNCT_ADD = 6'h20;
    localparam logic [31:0] HALT_WORD = 32'h0000_003F;

    logic [31:0] inst_mem [0:IMEM_DEPTH-1];
    logic [31:0] data_mem [0:DMEM_DEPTH-1];
    logic [31:0] rf       [0:31];

    logic [31:0] pc;
    logic [31:0] pc_d;
    logic [31:0] instruction;

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] ea;
    logic [5:0]  dm_idx;
    logic        halt;

    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        dm_we;

    // pc counts words; the fetch index simply drops the upper bits so it wraps.
    assign instruction = inst_mem[pc[IMEM_AW-1:0]];

    assign op       = instruction[31:26];
    assign rs       = instruction[25:21];
    assign rt       = instruction[20:16];
    assign rd       = instruction[15:11];
    assign funct    = instruction[5:0];
    assign imm_sext = {{16{instruction[15]}}, instruction[15:0]};

    assign rs_val = (rs == 5'd0) ? 32'd0 : rf[rs];
    assign rt_val = (rt == 5'd0) ? 32'd0 : rf[rt];

    // Byte address; only the word index within a 64-word window is used.
    assign ea     = rs_val + imm_sext;
    assign dm_idx = ea[7:2];
    assign halt   = (instruction == HALT_WORD);

    always_comb begin
        pc_d  = halt ? pc : pc + 32'd1;
        rf_we = 1'b0;
        rf_wa = 5'd0;
        rf_wd = 32'd0;
        dm_we = 1'b0;
        if (!halt) begin
            case (op)
                OP_RTYPE: begin
                    if (funct == FUNCT_ADD) begin
                        rf_we = (rd != 5'd0);
                        rf_wa = rd;
                        rf_wd = rs_val + rt_val;
                    end
                end
                OP_LW: begin
                    rf_we = (rt != 5'd0);
                    rf_wa = rt;
                    rf_wd = data_mem[dm_idx];
                end
                OP_SW: begin
                    dm_we = 1'b1;
                end
                default: begin
                end
            endcase
        end
        // Reset cancels whatever instruction is present at that edge.
        if (!reset) begin
            pc_d  = 32'd0;
            rf_we = 1'b0;
            dm_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        pc <= pc_d;
        if (rf_we) begin
            rf[rf_wa] <= rf_wd;
        end
        if (dm_we) begin
            data_mem[dm_idx] <= rt_val;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{pc[31:IMEM_AW], ea[31:8], ea[1:0], instruction[10:6]};

endmodule

// File: tb/tb_toy_processor.sv
// Directed bench for toy_processor: preloads programs, queues expected state,
// and a negedge monitor compares architectural state against the queue.
module tb_toy_processor;

    localparam logic [31:0] NOP  = 32'hFFFF_FFFF;
    localparam logic [31:0] HALT = 32'h0000_003F;

    localparam int K_PC   = 0;
    localparam int K_RF   = 1;
    localparam int K_DM   = 2;
    localparam int K_INST = 3;

    logic clk;
    logic reset;

    logic [31:0] exp_q[$];
    int          kind_q[$];
    int          idx_q[$];
    string       name_q[$];

    int pass_cnt;
    int chk_cnt;

    toy_processor #(.IMEM_DEPTH(64), .DMEM_DEPTH(64)) dut (
        .clk  (clk),
        .reset(reset)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        reset    = 1'b0;
        pass_cnt = 0;
        chk_cnt  = 0;
    end

    function automatic logic [31:0] observe(input int kind, input int idx);
        case (kind)
            K_PC:    observe = dut.pc;
            K_RF:    observe = dut.rf[idx];
            K_DM:    observe = dut.data_mem[idx];
            default: observe = dut.instruction;
        endcase
    endfunction

    // monitor: architectural state is stable at the falling edge
    initial begin
        logic [31:0] exp_v;
        logic [31:0] act_v;
        int          kind;
        int          idx;
        string       nm;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                kind  = kind_q.pop_front();
                idx   = idx_q.pop_front();
                nm    = name_q.pop_front();
                act_v = observe(kind, idx);
                chk_cnt++;
                if (act_v === exp_v) begin
                    pass_cnt++;
                end else begin
                    $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act_v, exp_v);
                end
            end
        end
    end

    // driver tasks
    task automatic push(input string nm, input int kind, input int idx, input logic [31:0] v);
        name_q.push_back(nm);
        kind_q.push_back(kind);
        idx_q.push_back(idx);
        exp_q.push_back(v);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        do begin
            @(negedge clk);
            #1;
            waited++;
        end while (exp_q.size() > 0 && waited < 20);
        if (exp_q.size() > 0) begin
            chk_cnt++;
            $display("FAIL drain_timeout: got %0d pending expected 0 pending", exp_q.size());
            exp_q.delete();
            kind_q.delete();
            idx_q.delete();
            name_q.delete();
        end
    endtask

    // Hold reset for two edges with all of imem set to NOP; caller then writes
    // the program and data while the core is still held.
    task automatic begin_load();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            dut.inst_mem[i] = NOP;
        end
        step(2);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        // ---------------- reset ----------------
        @(negedge clk);
        for (int i = 0; i < 32; i++) dut.rf[i] = 32'hA000_0000 + i;
        dut.rf[0] = 32'd0;
        for (int i = 0; i < 64; i++) dut.data_mem[i] = 32'hD000_0000 + i;
        begin_load();
        dut.inst_mem[0] = HALT;
        step(1);
        push("reset_pc", K_PC, 0, 32'd0);
        push("reset_inst", K_INST, 0, HALT);
        push("reset_rf7", K_RF, 7, 32'hA000_0007);
        push("reset_dm9", K_DM, 9, 32'hD000_0009);
        drain();
        release_reset();
        step(3);
        push("halt_at0_pc", K_PC, 0, 32'd0);
        push("halt_at0_rf7", K_RF, 7, 32'hA000_0007);
        drain();

        // ---------------- add ----------------
        begin_load();
        dut.rf[1] = 32'd5;
        dut.rf[2] = 32'd7;
        dut.inst_mem[0] = 32'h0022_1820;  // add $3,$1,$2
        dut.inst_mem[1] = HALT;
        drain();
        release_reset();
        step(1);
        push("add_rf3", K_RF, 3, 32'd12);
        push("add_pc", K_PC, 0, 32'd1);
        drain();

        begin_load();
        dut.rf[1] = 32'hFFFF_FFFF;
        dut.rf[2] = 32'd1;
        dut.inst_mem[0] = 32'h0022_1820;
        dut.inst_mem[1] = HALT;
        drain();
        release_reset();
        step(1);
        push("add_wrap_rf3", K_RF, 3, 32'd0);
        drain();

        // ---------------- lw / sw ----------------
        begin_load();
        dut.data_mem[2] = 32'h0000_1234;
        dut.data_mem[3] = 32'd0;
        dut.rf[4] = 32'd0;
        dut.inst_mem[0] = 32'h8C85_0008;  // lw $5,8($4)
        dut.inst_mem[1] = 32'hAC85_000C;  // sw $5,12($4)
        dut.inst_mem[2] = HALT;
        drain();
        release_reset();
        step(2);
        push("lw_rf5", K_RF, 5, 32'h0000_1234);
        push("sw_dm3", K_DM, 3, 32'h0000_1234);
        push("lwsw_pc", K_PC, 0, 32'd2);
        drain();

        begin_load();
        dut.rf[4] = 32'd16;
        dut.rf[8] = 32'h0000_00FC;
        dut.data_mem[3] = 32'hCAFE_BABE;
        dut.data_mem[1] = 32'h1111_2222;
        dut.inst_mem[0] = 32'h8C86_FFFC;  // lw $6,-4($4)
        dut.inst_mem[1] = 32'h8D07_0008;  // lw $7,8($8): ea 0x104 wraps to word 1
        dut.inst_mem[2] = HALT;
        drain();
        release_reset();
        step(2);
        push("lw_negoff_rf6", K_RF, 6, 32'hCAFE_BABE);
        push("lw_wrap_rf7", K_RF, 7, 32'h1111_2222);
        drain();

        // ---------------- $0 protection ----------------
        begin_load();
        dut.rf[0] = 32'd0;
        dut.rf[1] = 32'd5;
        dut.rf[2] = 32'd7;
        dut.rf[4] = 32'd0;
        dut.data_mem[2] = 32'h0000_1234;
        dut.inst_mem[0] = 32'h0022_0020;  // add $0,$1,$2
        dut.inst_mem[1] = 32'h8C80_0008;  // lw $0,8($4)
        dut.inst_mem[2] = 32'h0001_4820;  // add $9,$0,$1
        dut.inst_mem[3] = HALT;
        drain();
        release_reset();
        step(1);
        push("r0_after_add", K_RF, 0, 32'd0);
        drain();
        step(0);
        @(posedge clk);
        #1;
        push("r0_after_lw", K_RF, 0, 32'd0);
        drain();
        @(posedge clk);
        #1;
        push("r0_reads_zero_rf9", K_RF, 9, 32'd5);
        drain();

        // ---------------- halt ----------------
        begin_load();
        dut.rf[1] = 32'd5;
        dut.rf[2] = 32'd7;
        dut.rf[11] = 32'h0000_0BAD;
        dut.data_mem[0] = 32'd0;
        dut.data_mem[1] = 32'h0000_0B0B;
        dut.inst_mem[0] = 32'h0022_1820;  // add $3,$1,$2
        dut.inst_mem[1] = 32'hAC03_0000;  // sw $3,0($0)
        dut.inst_mem[2] = 32'h0063_5020;  // add $10,$3,$3
        dut.inst_mem[5] = HALT;
        dut.inst_mem[6] = 32'h0022_5820;  // add $11,$1,$2 (must not run)
        dut.inst_mem[7] = 32'hAC01_0004;  // sw $1,4($0) (must not run)
        drain();
        release_reset();
        step(5);
        push("halt_reach_pc", K_PC, 0, 32'd5);
        drain();
        step(4);
        push("halt_hold_pc", K_PC, 0, 32'd5);
        push("halt_rf10", K_RF, 10, 32'd24);
        push("halt_dm0", K_DM, 0, 32'd12);
        push("halt_no_rf11", K_RF, 11, 32'h0000_0BAD);
        push("halt_no_dm1", K_DM, 1, 32'h0000_0B0B);
        drain();

        // ---------------- reset mid-run ----------------
        begin_load();
        dut.rf[1] = 32'd5;
        dut.rf[2] = 32'd7;
        dut.rf[12] = 32'h0000_0055;
        dut.inst_mem[0] = 32'h0022_1820;  // add $3,$1,$2
        dut.inst_mem[3] = 32'h0021_6020;  // add $12,$1,$1
        dut.inst_mem[4] = HALT;
        drain();
        release_reset();
        step(3);
        push("midrst_pc3", K_PC, 0, 32'd3);
        drain();
        reset = 1'b0;
        step(1);
        push("midrst_pc0", K_PC, 0, 32'd0);
        push("midrst_no_rf12", K_RF, 12, 32'h0000_0055);
        drain();
        dut.rf[3] = 32'd0;
        release_reset();
        step(5);
        push("rerun_pc", K_PC, 0, 32'd4);
        push("rerun_rf3", K_RF, 3, 32'd12);
        push("rerun_rf12", K_RF, 12, 32'd10);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
